// File: rtl/io_bus_pkg.sv
// Shared types for the I/O bus-cycle sequencer: FSM states, counter width
// and requester port encodings.
package io_bus_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/io_rr_arb2.sv
// Two-request round-robin arbiter. The last-served pointer advances only when
// the sequencer accepts the current grant.
module io_rr_arb2
  import io_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output port_e      grant,
  output logic       valid
);

  port_e last;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = PORT0;
    valid = |req;
    if (req == 2'b11) begin
      grant = (last == PORT0) ? PORT1 : PORT0;
    end else if (req[1]) begin
      grant = PORT1;
    end
  end

  // Reset value claims port 1 was served last, so port 0 wins the first tie.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT1;
    end else if (accept && valid) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/io_bus_cycle_ctrl.sv
// Bus-cycle sequencer with two-port round-robin arbitration producing
// active-low CS/RD/WR strobes. Optional IO_READY_WAIT_EN adds a Ready stall.
module io_bus_cycle_ctrl
  import io_bus_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] Bus_Addr,
  output logic [DATA_W-1:0] Bus_WData,
  input  logic [DATA_W-1:0] Bus_RData,
`ifdef IO_READY_WAIT_EN
  input  logic              Ready,
`endif
  output logic              Bus_Drive,
  output logic              Enable,
  output logic              CS_Out,
  output logic              RD_Out,
  output logic              WR_Out
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  port_e            cur_port;
  logic             cur_we;
  logic             accept;
  logic             strobe_done;
  logic             last_cycle;
  port_e            grant;
  logic             grant_valid;

  io_rr_arb2 u_arb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .req    ({Req1, Req0}),
    .accept (accept),
    .grant  (grant),
    .valid  (grant_valid)
  );

`ifdef IO_READY_WAIT_EN
  assign strobe_done = (cnt == '0) && Ready;
`else
  assign strobe_done = (cnt == '0);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        // Counter parks at zero while a stalled peripheral holds Ready low.
        if (strobe_done) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from registered state only, so reset forces them inactive
  // asynchronously and Req never reaches them combinationally.
  always_comb begin
    last_cycle = (state == HOLD) && (cnt == '0);
    CS_Out     = (state == IDLE);
    Enable     = (state != IDLE);
    Bus_Drive  = (state != IDLE) && cur_we;
    RD_Out     = !((state == STROBE) && !cur_we);
    WR_Out     = !((state == STROBE) && cur_we);
    Ack0       = last_cycle && (cur_port == PORT0);
    Ack1       = last_cycle && (cur_port == PORT1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_port  <= PORT0;
      cur_we    <= 1'b0;
      Bus_Addr  <= '0;
      Bus_WData <= '0;
      RData     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cur_port  <= grant;
        cur_we    <= (grant == PORT1) ? We1    : We0;
        Bus_Addr  <= (grant == PORT1) ? Addr1  : Addr0;
        Bus_WData <= (grant == PORT1) ? WData1 : WData0;
      end
      if ((state == STROBE) && strobe_done && !cur_we) begin
        RData <= Bus_RData;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_cycle_ctrl.sv
// Directed self-checking bench for io_bus_cycle_ctrl; per-cycle output
// activity is packed into bit masks indexed by cycle number.
module tb_io_bus_cycle_ctrl;

  logic       Clk;
  logic       Rst_n;
  logic       Req0, Req1, We0, We1;
  logic [7:0] Addr0, Addr1, WData0, WData1;
  logic       Ack0, Ack1;
  logic [7:0] RData, Bus_Addr, Bus_WData, Bus_RData;
  logic       Bus_Drive, Enable, CS_Out, RD_Out, WR_Out;
`ifdef IO_READY_WAIT_EN
  logic       Ready;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cs_m, rd_m, wr_m, en_m, drv_m, ack0_m, ack1_m;
  logic [7:0]  rdata_at [32];
  logic [7:0]  addr_at  [32];
  logic [7:0]  wdata_at [32];
  logic [3:0]  ack_seq;
  int          n_acks;

  io_bus_cycle_ctrl dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Req0      (Req0),
    .Req1      (Req1),
    .We0       (We0),
    .We1       (We1),
    .Addr0     (Addr0),
    .Addr1     (Addr1),
    .WData0    (WData0),
    .WData1    (WData1),
    .Ack0      (Ack0),
    .Ack1      (Ack1),
    .RData     (RData),
    .Bus_Addr  (Bus_Addr),
    .Bus_WData (Bus_WData),
    .Bus_RData (Bus_RData),
`ifdef IO_READY_WAIT_EN
    .Ready     (Ready),
`endif
    .Bus_Drive (Bus_Drive),
    .Enable    (Enable),
    .CS_Out    (CS_Out),
    .RD_Out    (RD_Out),
    .WR_Out    (WR_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Enters and leaves at the start of a cycle (just after a rising edge).
  task automatic do_reset();
    Rst_n = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  // Drives the enabled requesters for ncyc cycles, recording outputs at each
  // falling edge. Without keep, a port drops Req the cycle after its Ack.
  task automatic run(input int ncyc, input bit use0, input bit use1,
                     input bit keep, input bit stall);
    bit done0 = 1'b0;
    bit done1 = 1'b0;
    cs_m = '0; rd_m = '0; wr_m = '0; en_m = '0; drv_m = '0;
    ack0_m = '0; ack1_m = '0; ack_seq = '0; n_acks = 0;
    for (int k = 0; k < ncyc; k++) begin
`ifdef IO_READY_WAIT_EN
      Ready = !(stall && k >= 2 && k <= 4);
`endif
      Req0 = use0 && !done0;
      Req1 = use1 && !done1;
      @(negedge Clk);
      if (!CS_Out)   cs_m[k]   = 1'b1;
      if (!RD_Out)   rd_m[k]   = 1'b1;
      if (!WR_Out)   wr_m[k]   = 1'b1;
      if (Enable)    en_m[k]   = 1'b1;
      if (Bus_Drive) drv_m[k]  = 1'b1;
      if (Ack0)      ack0_m[k] = 1'b1;
      if (Ack1)      ack1_m[k] = 1'b1;
      rdata_at[k] = RData;
      addr_at[k]  = Bus_Addr;
      wdata_at[k] = Bus_WData;
      if (Ack0 || Ack1) begin
        if (n_acks < 4) ack_seq[3 - n_acks] = Ack1;
        n_acks++;
      end
      if (Ack0 && !keep) done0 = 1'b1;
      if (Ack1 && !keep) done1 = 1'b1;
      @(posedge Clk);
      #1;
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0; Bus_RData = '0;
`ifdef IO_READY_WAIT_EN
    Ready = 1'b1;
`endif
    #12;
    check("rst_cs",   32'(CS_Out),    32'h1);
    check("rst_rd",   32'(RD_Out),    32'h1);
    check("rst_wr",   32'(WR_Out),    32'h1);
    check("rst_en",   32'(Enable),    32'h0);
    check("rst_drv",  32'(Bus_Drive), 32'h0);
    check("rst_ack",  32'({Ack1, Ack0}), 32'h0);
    check("rst_rdat", 32'(RData),     32'h0);
    check("rst_addr", 32'(Bus_Addr),  32'h0);
    check("rst_wdat", 32'(Bus_WData), 32'h0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Port 0 write
    We0 = 1; Addr0 = 8'h3C; WData0 = 8'hA5; Bus_RData = 8'h77;
    run(10, 1, 0, 0, 0);
    check("w_cs",    cs_m,   32'h1E);
    check("w_wr",    wr_m,   32'h0C);
    check("w_rd",    rd_m,   32'h00);
    check("w_en",    en_m,   32'h1E);
    check("w_drv",   drv_m,  32'h1E);
    check("w_ack0",  ack0_m, 32'h10);
    check("w_ack1",  ack1_m, 32'h00);
    check("w_addr",  32'(addr_at[1]),  32'h3C);
    check("w_wdata", 32'(wdata_at[1]), 32'hA5);
    check("w_rdata_untouched", 32'(rdata_at[4]), 32'h00);

    // Port 1 read
    We1 = 0; Addr1 = 8'h81; WData1 = 8'h00; Bus_RData = 8'h5A;
    run(10, 0, 1, 0, 0);
    check("r_cs",    cs_m,   32'h1E);
    check("r_rd",    rd_m,   32'h0C);
    check("r_wr",    wr_m,   32'h00);
    check("r_drv",   drv_m,  32'h00);
    check("r_ack1",  ack1_m, 32'h10);
    check("r_ack0",  ack0_m, 32'h00);
    check("r_addr",  32'(addr_at[1]),  32'h81);
    check("r_rdata_pre",  32'(rdata_at[3]), 32'h00);
    check("r_rdata_ack",  32'(rdata_at[4]), 32'h5A);

    // Port 0 write with Ready low for three cycles from STROBE entry
    We0 = 1; Addr0 = 8'h44; WData0 = 8'h99; Bus_RData = 8'h77;
    run(10, 1, 0, 0, 1);
`ifdef IO_READY_WAIT_EN
    check("s_wr",   wr_m,   32'h3C);
    check("s_cs",   cs_m,   32'h7E);
    check("s_ack0", ack0_m, 32'h40);
`else
    check("s_wr",   wr_m,   32'h0C);
    check("s_cs",   cs_m,   32'h1E);
    check("s_ack0", ack0_m, 32'h10);
`endif
    check("s_rdata_hold", 32'(rdata_at[9]), 32'h5A);

    // Simultaneous requests right after reset
    do_reset();
    We0 = 0; Addr0 = 8'h11; We1 = 1; Addr1 = 8'h22; WData1 = 8'h66;
    run(12, 1, 1, 0, 0);
    check("d_ack0", ack0_m, 32'h010);
    check("d_ack1", ack1_m, 32'h200);
    check("d_cs",   cs_m,   32'h3DE);
    check("d_addr0", 32'(addr_at[1]), 32'h11);
    check("d_addr1", 32'(addr_at[6]), 32'h22);
    check("d_drv",  drv_m,  32'h3C0);

    // Continuous requests from both ports
    run(21, 1, 1, 1, 0);
    check("c_nacks", 32'(n_acks),  32'd4);
    check("c_order", 32'(ack_seq), 32'b0101);

    // Reset asserted during the STROBE phase of a read
    do_reset();
    We0 = 0; Addr0 = 8'h10; Bus_RData = 8'hC3;
    Req0 = 1'b1;
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("m_rd_before", 32'(RD_Out), 32'h0);
    Rst_n = 1'b0;
    #1;
    check("m_cs_async", 32'(CS_Out), 32'h1);
    check("m_rd_async", 32'(RD_Out), 32'h1);
    check("m_en_async", 32'(Enable), 32'h0);
    check("m_no_ack",   32'({Ack1, Ack0}), 32'h0);
    Req0 = 1'b0;
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(posedge Clk); #1;
    run(10, 1, 0, 0, 0);
    check("m_re_ack0",  ack0_m, 32'h10);
    check("m_re_rd",    rd_m,   32'h0C);
    check("m_re_rdata", 32'(rdata_at[4]), 32'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
